// File: rtl/brisc_pkg.sv
// Shared widths, boot/exception vectors, NOP encoding and fetch FSM states.
package brisc_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_BOOT   = 32'h0000_1000;
  localparam logic [XLEN-1:0] PC_EXCEPT = 32'h0000_2000;
  localparam logic [ILEN-1:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // Sequential PC advance; wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch: one instr per (mem latency + 2) cycles, held while stall_i.
// Flushes discard in-flight data; FETCH_ALIGN_CHECK_EN traps misaligned redirect targets.
module fetch_stage
  import brisc_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR   = PC_BOOT,
  parameter logic [XLEN-1:0] EXCEPT_ADDR = PC_EXCEPT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            except_i,
  input  logic            stall_i,
  output logic            valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            misaligned_o
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_pc_o;
  logic [ILEN-1:0] r_instr;
  logic            r_valid;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_flush_tgt;
  logic            w_flush;
  logic            w_accept;
  logic            w_consume;
  logic            w_enter_fetch;

  assign w_flush   = except_i | redirect_i;
  assign w_accept  = (r_state == FETCH) & imem_ready_i & ~w_flush;
  assign w_consume = (r_state == HOLD) & ~stall_i;

`ifdef FETCH_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_misaligned;

  assign w_misaligned = redirect_i & ~except_i & (redirect_pc_i[1:0] != 2'b00);
  assign w_flush_tgt  = (except_i | w_misaligned) ? EXCEPT_ADDR : redirect_pc_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misaligned <= 1'b0;
    else        r_misaligned <= w_misaligned;
  end

  assign misaligned_o = r_misaligned;
`else
  assign w_flush_tgt  = except_i ? EXCEPT_ADDR : (redirect_pc_i & ~XLEN'(3));
  assign misaligned_o = 1'b0;
`endif

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_flush)       w_pc_nxt = w_flush_tgt;
    else if (w_accept) w_pc_nxt = pc_inc(r_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A flush arriving with the response re-fetches immediately; without it we must drain first.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  w_state_nxt = FETCH;
      FETCH: begin
        if (w_flush)           w_state_nxt = imem_ready_i ? FETCH : DROP;
        else if (imem_ready_i) w_state_nxt = HOLD;
      end
      HOLD:  if (w_flush || !stall_i) w_state_nxt = FETCH;
      DROP:  if (imem_ready_i)        w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o = (r_state == FETCH) || (r_state == DROP);
  end

  // The request address only moves when a new request is launched, keeping it stable while outstanding.
  assign w_enter_fetch = (w_state_nxt == FETCH) && ((r_state != FETCH) || imem_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= BOOT_ADDR;
      r_req_addr <= BOOT_ADDR;
      r_valid    <= 1'b0;
      r_instr    <= NOP;
      r_pc_o     <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_enter_fetch) r_req_addr <= w_pc_nxt;
      if (w_flush || w_consume) begin
        r_valid <= 1'b0;
        r_instr <= NOP;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= imem_rdata_i;
        r_pc_o  <= r_pc;
      end
    end
  end

  assign imem_addr_o = r_req_addr;
  assign valid_o     = r_valid;
  assign instr_o     = r_instr;
  assign pc_o        = r_pc_o;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: driver plays memory and pipeline control, monitor checks outputs.
module tb_fetch_stage;
  localparam logic [31:0] BOOT  = 32'h0000_1000;
  localparam logic [31:0] EXC   = 32'h0000_2000;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        except_i;
  logic        stall_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        misaligned_o;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .except_i(except_i), .stall_i(stall_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .misaligned_o(misaligned_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_req_q[$];
  logic [63:0] exp_out_q[$];
  logic [31:0] m_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  function automatic logic [31:0] exp_target(input bit exc, input logic [31:0] t);
    logic [31:0] r;
    if (exc) r = EXC;
`ifdef FETCH_ALIGN_CHECK_EN
    else if (t[1:0] != 2'b00) r = EXC;
    else r = t;
`else
    else r = t & 32'hFFFF_FFFC;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // Monitor: samples on the falling edge, inputs were driven 2ns after the rising edge.
  initial begin
    logic        p_req, p_rdy, p_vld, p_stall, p_flush, p_mis;
    logic [31:0] p_pc, p_instr;
    p_req = 0; p_rdy = 0; p_vld = 0; p_stall = 0; p_flush = 0; p_mis = 0;
    p_pc = '0; p_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctl", {61'b0, imem_req_o, valid_o, misaligned_o}, 64'h0);
        chk("rst_addr", {32'b0, imem_addr_o}, {32'b0, BOOT});
        chk("rst_dat", {instr_o, pc_o}, {NOP_I, 32'h0});
        p_req = 0; p_rdy = 0; p_vld = 0; p_stall = 0; p_flush = 0; p_mis = 0;
        continue;
      end
      if (imem_req_o && (!p_req || p_rdy)) begin
        if (exp_req_q.size() == 0) fail_unexp("req_unexp", {32'b0, imem_addr_o});
        else chk("req_addr", {32'b0, imem_addr_o}, {32'b0, exp_req_q.pop_front()});
      end
      if (valid_o && !p_vld) begin
        if (exp_out_q.size() == 0) fail_unexp("deliver_unexp", {pc_o, instr_o});
        else chk("deliver", {pc_o, instr_o}, exp_out_q.pop_front());
      end
      if (p_vld && p_stall && !p_flush) begin
        chk("stall_dat", {pc_o, instr_o}, {p_pc, p_instr});
        chk("stall_ctl", {62'b0, valid_o, imem_req_o}, 64'h2);
      end
      if (p_flush || (p_vld && !p_stall))
        chk("clear", {31'b0, valid_o, instr_o}, {32'b0, NOP_I});
      chk("misaligned", {63'b0, misaligned_o}, {63'b0, p_mis});
      p_req   = imem_req_o;
      p_rdy   = imem_ready_i;
      p_vld   = valid_o;
      p_stall = stall_i;
      p_flush = redirect_i | except_i;
      p_pc    = pc_o;
      p_instr = instr_o;
`ifdef FETCH_ALIGN_CHECK_EN
      p_mis = redirect_i && !except_i && (redirect_pc_i[1:0] != 2'b00);
`else
      p_mis = 1'b0;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    imem_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    except_i      = 1'b0;
    stall_i       = 1'b0;
    imem_rdata_i  = $urandom;
    redirect_pc_i = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      quiet();
      stall_i = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic respond();
    imem_ready_i = 1'b1;
    imem_rdata_i = hash(imem_addr_o);
  endtask

  task automatic drive_flush(input logic [31:0] tgt, input bit exc, input bit rd);
    except_i      = exc;
    redirect_i    = rd | ~exc;
    redirect_pc_i = tgt;
    m_next        = exp_target(exc, tgt);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req_o && n < 50) begin
      quiet();
      step();
      n++;
    end
    if (!imem_req_o) chk("req_timeout", {63'b0, imem_req_o}, 64'h1);
  endtask

  // mode 0/1: normal fetch + stall; 2: flush in HOLD; 3: flush while outstanding; 4: flush with response
  task automatic do_txn(input int mode, input int lat, input int stl,
                        input logic [31:0] tgt, input bit exc, input bit rd);
    logic [31:0] a;
    a = m_next;
    wait_req();
    if (mode == 3) begin
      idle_cycles($urandom_range(0, 2));
      quiet(); drive_flush(tgt, exc, rd); step();
      if ($urandom_range(0, 1) == 1) begin
        quiet(); drive_flush(rand_tgt(), 1'($urandom_range(0, 3) == 0), 1'b1); step();
      end
      idle_cycles(lat);
      quiet(); respond(); exp_req_q.push_back(m_next); step();
    end else if (mode == 4) begin
      idle_cycles(lat);
      quiet(); respond(); drive_flush(tgt, exc, rd); exp_req_q.push_back(m_next); step();
    end else begin
      idle_cycles(lat);
      quiet(); respond(); exp_out_q.push_back({a, hash(a)});
      if (mode != 2) begin
        m_next = a + 32'd4;
        exp_req_q.push_back(m_next);
      end
      step();
      quiet(); stall_i = 1'b1;
      repeat (stl) step();
      quiet();
      if (mode == 2) begin
        stall_i = 1'($urandom_range(0, 1));
        drive_flush(tgt, exc, rd);
        exp_req_q.push_back(m_next);
      end
      step();
    end
    quiet();
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    m_next = BOOT;
    exp_req_q.push_back(BOOT);
    repeat (3) step();
    rst_n = 1'b1;

    do_txn(0, 5, 0, 32'h0, 0, 0);
    do_txn(0, 1, 4, 32'h0, 0, 0);
    do_txn(3, 2, 0, 32'h0000_1400, 0, 1);
    do_txn(0, 0, 1, 32'h0, 0, 0);
    do_txn(4, 1, 0, 32'h0000_3000, 1, 1);
    do_txn(2, 0, 1, 32'hFFFF_FFFC, 0, 1);
    do_txn(0, 2, 0, 32'h0, 0, 0);
    do_txn(0, 0, 0, 32'h0, 0, 0);
    do_txn(2, 1, 2, 32'h0000_1402, 0, 1);
    do_txn(0, 1, 0, 32'h0, 0, 0);

    for (int i = 0; i < 60; i++)
      do_txn($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             rand_tgt(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    // Abandon an outstanding request with reset; the memory side simply never answers it.
    wait_req();
    idle_cycles(2);
    rst_n = 1'b0;
    quiet();
    repeat (3) step();
    m_next = BOOT;
    exp_req_q.push_back(BOOT);
    rst_n = 1'b1;
    do_txn(0, 3, 1, 32'h0, 0, 0);
    wait_req();
    repeat (3) step();

    chk("sb_req_drain", 64'(exp_req_q.size()), 64'h0);
    chk("sb_out_drain", 64'(exp_out_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default PC_BOOT (0x00001000), PC loaded at reset.
REQ-002 SHALL have parameter EXCEPT_ADDR, default PC_EXCEPT (0x00002000), exception vector.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  XLEN  request address
- imem_ready_i  in  1  response valid, completes the request
- imem_rdata_i  in  ILEN  response instruction
- redirect_i  in  1  branch/JAL taken
- redirect_pc_i  in  XLEN  redirect target
- except_i  in  1  exception
- stall_i  in  1  decode not ready
- valid_o  out  1  instr_o/pc_o valid
- instr_o  out  ILEN  fetched instruction
- pc_o  out  XLEN  PC of instr_o
- misaligned_o  out  1  misaligned-target pulse

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, HOLD and DROP; at most one request is outstanding.
REQ-006 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-007 On entry to FETCH, the block SHALL latch pc into a request-address register.
- imem_addr_o SHALL equal that register.
- imem_req_o SHALL be 1 in FETCH and DROP, and 0 otherwise.
- imem_addr_o SHALL stay stable until imem_ready_i.
REQ-008 FETCH with imem_ready_i (no flush) SHALL, on the next edge:
- set instr_o to imem_rdata_i, pc_o to pc, valid_o to 1;
- set pc to pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000);
- go to HOLD.
REQ-009 HOLD with stall_i=1 SHALL hold all outputs unchanged.
REQ-010 HOLD with stall_i=0 SHALL consume the instruction: valid_o goes to 0 and instr_o to NOP (0x00000013) next cycle, then FETCH.
REQ-011 A flush is except_i=1 or redirect_i=1; except_i SHALL have priority.
- Flush target SHALL be EXCEPT_ADDR if except_i=1, otherwise redirect_pc_i.
REQ-012 A flush in any state SHALL, next cycle: load pc with the target, clear valid_o, and set instr_o to NOP.
REQ-013 Next state after a flush SHALL be:
- FETCH without imem_ready_i: DROP;
- FETCH with imem_ready_i in the same cycle: FETCH at the target, with the response discarded;
- IDLE or HOLD: FETCH.
REQ-014 DROP SHALL keep the old address and wait for imem_ready_i, discard the data, then go to FETCH at the current pc.
- A flush while in DROP SHALL update pc and stay in DROP.
REQ-015 Fetch throughput SHALL be at most one instruction per (memory latency + 2) cycles; no prefetch.

Reset
REQ-016 While rst_n=0, outputs SHALL be asynchronously forced to:
- pc=BOOT_ADDR, state=IDLE;
- imem_req_o=0, imem_addr_o=BOOT_ADDR;
- valid_o=0, instr_o=NOP, pc_o=0, misaligned_o=0.
REQ-017 Reset mid-request SHALL abandon the request.
- The memory side SHALL tolerate the dropped request.
- The first request after release SHALL be to BOOT_ADDR.

Configuration
REQ-018 With FETCH_ALIGN_CHECK_EN defined, a redirect target with [1:0]!=0 SHALL:
- pulse misaligned_o for one cycle;
- load pc with EXCEPT_ADDR instead of the target.
REQ-019 Without FETCH_ALIGN_CHECK_EN, the block SHALL force target[1:0] to 0 and tie misaligned_o to 0; the port SHALL exist in both builds.

Structure
REQ-020 brisc_pkg SHALL hold the fetch_state_e enum (IDLE, FETCH, HOLD, DROP).
- The block SHALL reuse the package's ILEN, XLEN, PC_BOOT, PC_EXCEPT and NOP.
REQ-021 The block SHALL be a single module with no sub-modules.

Verification
REQ-022 Boot: release reset, imem_ready_i 5 cycles after request -> first imem_addr_o=0x1000; then valid_o=1, pc_o=0x1000; next request 0x1004.
REQ-023 Stall: hold stall_i=1 for 4 cycles in HOLD -> outputs constant, imem_req_o=0; release -> request pc+4.
REQ-024 Redirect during outstanding request: redirect_pc_i=0x1400 in FETCH -> DROP, old response discarded (valid_o stays 0), next request 0x1400.
REQ-025 Simultaneous except_i and redirect_i with imem_ready_i -> response discarded, next request 0x2000.
REQ-026 Wrap: pc=0xFFFFFFFC fetched -> next request 0x00000000.
REQ-027 Misaligned redirect 0x1402 -> with FETCH_ALIGN_CHECK_EN: misaligned_o pulse, next fetch 0x2000; without it: next fetch 0x1400.
